uart_cmd_rx: RTL and testbench



---
 rtl/uart_cmd_rx_if.sv | 31 +++
 rtl/uart_cmd_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
// Serial input and decoded-output bundle of the host-side command receiver.
// The slave modport is the receiver; the master modport is the host/observer side.
interface uart_cmd_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_report_req;
    logic       o_clear_req;
    logic       o_frame_err;
    logic       o_parity_err;

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_report_req,
        output o_clear_req,
        output o_frame_err,
        output o_parity_err
    );

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_report_req,
        input  o_clear_req,
        input  o_frame_err,
        input  o_parity_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART receiver (8N1, LSB first) that turns 'S'/'s' and 'C'/'c' into one-cycle request pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches.
module uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 87,
    parameter logic [7:0] CMD_REPORT   = 8'h53,
    parameter logic [7:0] CMD_CLEAR    = 8'h43
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_rx_if.slave  bus
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_e;

    // Lower-case variant of each command letter is accepted as well.
    function automatic logic is_report(input logic [7:0] b);
        return (b == CMD_REPORT) || (b == (CMD_REPORT | 8'h20));
    endfunction

    function automatic logic is_clear(input logic [7:0] b);
        return (b == CMD_CLEAR) || (b == (CMD_CLEAR | 8'h20));
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    logic [1:0]    sync_q;
    logic          rx_s;
    state_e        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          dv_q;
    logic          report_q;
    logic          clear_q;
    logic          ferr_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q;
    logic          perr_q;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous line, preset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.i_Rx_Serial};
        end
    end

    // Frame FSM; every status/request output is a flop set only in the CLEANUP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            report_q  <= 1'b0;
            clear_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            dv_q     <= 1'b0;
            report_q <= 1'b0;
            clear_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= 3'd0;
                    state_q   <= rx_s ? IDLE : START;
                end
                START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (clk_cnt_q == HALF_END) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_END) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (clk_cnt_q == BIT_END) begin
                        clk_cnt_q <= '0;
                        par_bit_q <= rx_s;
                        state_q   <= STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
                STOP: begin
                    if (clk_cnt_q == BIT_END) begin
                        clk_cnt_q <= '0;
                        state_q   <= CLEANUP;
                        // Framing error outranks a parity error on the same frame.
                        if (!rx_s) begin
                            ferr_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bit_q != even_parity(shift_q)) begin
                            perr_q <= 1'b1;
`endif
                        end else begin
                            byte_q   <= shift_q;
                            dv_q     <= 1'b1;
                            report_q <= is_report(shift_q);
                            clear_q  <= is_clear(shift_q);
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CW'(1);
                    end
                end
                CLEANUP: begin
                    clk_cnt_q <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    clk_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Rx_DV      = dv_q;
    assign bus.o_Rx_Byte    = byte_q;
    assign bus.o_report_req = report_q;
    assign bus.o_clear_req  = clear_q;
    assign bus.o_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = perr_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised self-checking bench for uart_cmd_rx; frame outcomes come from a byte-level model.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_cmd_rx;
    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 2 + 4 + 8 * CPB + CPB + CPB;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 2 + 4 + 8 * CPB + CPB;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0]  held = 8'h00;
    logic [12:0] ev_q[$];
    int          evc_q[$];

    uart_cmd_rx_if ifc();

    uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle that has any pulse high is logged as {dv,rep,clr,fe,pe,byte}.
    always @(negedge clk) begin
        if ((ifc.o_Rx_DV | ifc.o_report_req | ifc.o_clear_req | ifc.o_frame_err | ifc.o_parity_err) === 1'b1) begin
            ev_q.push_back({ifc.o_Rx_DV, ifc.o_report_req, ifc.o_clear_req, ifc.o_frame_err,
                            ifc.o_parity_err, ifc.o_Rx_Byte});
            evc_q.push_back(cyc);
        end
    end

    // Expected logged event for one frame, from the byte, stop level, parity correctness and held byte.
    function automatic logic [12:0] model_frame(input logic [7:0] b, input logic stop_b,
                                                input logic par_ok, input logic [7:0] hb);
        logic rep;
        logic clr;
        if (!stop_b) return {5'b00010, hb};
        if (!par_ok) return {5'b00001, hb};
        rep = (b == 8'h53) || (b == 8'h73);
        clr = (b == 8'h43) || (b == 8'h63);
        return {1'b1, rep, clr, 2'b00, b};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        ifc.i_Rx_Serial = v;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                              output int start_cyc);
        int ones;
        ones = 0;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            ones += int'(b[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(((ones % 2) == 1) ^ par_flip);
`endif
        drive_bit(stop_b);
        ifc.i_Rx_Serial = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.i_Rx_Serial = 1'b1;
        wait_cycles(3);
        total++;
        if ({ifc.o_Rx_DV, ifc.o_report_req, ifc.o_clear_req, ifc.o_frame_err, ifc.o_parity_err} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {ifc.o_Rx_DV, ifc.o_report_req, ifc.o_clear_req, ifc.o_frame_err, ifc.o_parity_err});
        end
        total++;
        if (ifc.o_Rx_Byte !== 8'h00) begin
            bad++;
            $display("FAIL reset_byte: got %h expected 00", ifc.o_Rx_Byte);
        end
        rst = 1'b0;
        wait_cycles(200);
        total++;
        if (ev_q.size() != 0) begin
            bad++;
            $display("FAIL reset_quiet: got %0d pulse cycles expected 0", ev_q.size());
        end
        ev_q.delete();
        evc_q.delete();
    endtask

    task automatic test_report();
        int st;
        logic [12:0] exp_v;
        logic [12:0] got;
        int gc;
        exp_v = model_frame(8'h53, 1'b1, 1'b1, held);
        send_frame(8'h53, 1'b1, 1'b0, st);
        wait_cycles(4);
        total++;
        if (ev_q.size() != 1) begin
            bad++;
            $display("FAIL report_count: got %0d events expected 1", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            gc = evc_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL report_event: got %h expected %h", got, exp_v);
            end
            total++;
            if ((gc - st) < LAT - 1 || (gc - st) > LAT + 1) begin
                bad++;
                $display("FAIL report_latency: got %0d expected %0d+-1", gc - st, LAT);
            end
        end
        held = 8'h53;
        total++;
        if (ifc.o_Rx_Byte !== held) begin
            bad++;
            $display("FAIL report_hold: got %h expected %h", ifc.o_Rx_Byte, held);
        end
        ev_q.delete();
        evc_q.delete();
    endtask

    task automatic test_back_to_back();
        int st0;
        int st1;
        logic [12:0] e0;
        logic [12:0] e1;
        logic [12:0] got;
        e0 = model_frame(8'h63, 1'b1, 1'b1, held);
        e1 = model_frame(8'h41, 1'b1, 1'b1, 8'h63);
        send_frame(8'h63, 1'b1, 1'b0, st0);
        send_frame(8'h41, 1'b1, 1'b0, st1);
        wait_cycles(20);
        total++;
        if (ev_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d events expected 2", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            total++;
            if (got !== e0) begin
                bad++;
                $display("FAIL b2b_first: got %h expected %h", got, e0);
            end
            got = ev_q.pop_front();
            total++;
            if (got !== e1) begin
                bad++;
                $display("FAIL b2b_second: got %h expected %h", got, e1);
            end
        end
        held = 8'h41;
        total++;
        if (ifc.o_Rx_Byte !== held) begin
            bad++;
            $display("FAIL b2b_hold: got %h expected %h", ifc.o_Rx_Byte, held);
        end
        ev_q.delete();
        evc_q.delete();
    endtask

    task automatic test_frame_err();
        int st;
        logic [12:0] exp_v;
        logic [12:0] got;
        exp_v = model_frame(8'h53, 1'b0, 1'b1, held);
        send_frame(8'h53, 1'b0, 1'b0, st);
        wait_cycles(CPB);
        total++;
        if (ev_q.size() != 1) begin
            bad++;
            $display("FAIL ferr_count: got %0d events expected 1", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL ferr_event: got %h expected %h", got, exp_v);
            end
        end
        ev_q.delete();
        evc_q.delete();
        exp_v = model_frame(8'h43, 1'b1, 1'b1, held);
        send_frame(8'h43, 1'b1, 1'b0, st);
        wait_cycles(4);
        total++;
        if (ev_q.size() != 1) begin
            bad++;
            $display("FAIL ferr_next_count: got %0d events expected 1", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL ferr_next_event: got %h expected %h", got, exp_v);
            end
        end
        held = 8'h43;
        ev_q.delete();
        evc_q.delete();
    endtask

    task automatic test_glitch_and_reset();
        int st;
        logic [7:0] b;
        logic [12:0] exp_v;
        logic [12:0] got;
        ifc.i_Rx_Serial = 1'b0;
        wait_cycles(2);
        ifc.i_Rx_Serial = 1'b1;
        wait_cycles(100);
        total++;
        if (ev_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_quiet: got %0d events expected 0", ev_q.size());
        end
        // Abort 8'h53 with a one-cycle reset at the start of data bit 4.
        b = 8'h53;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rst = 1'b1;
        ifc.i_Rx_Serial = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        held = 8'h00;
        wait_cycles(100);
        total++;
        if (ev_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d events expected 0", ev_q.size());
        end
        ev_q.delete();
        evc_q.delete();
        exp_v = model_frame(8'h53, 1'b1, 1'b1, held);
        send_frame(8'h53, 1'b1, 1'b0, st);
        wait_cycles(4);
        total++;
        if (ev_q.size() != 1) begin
            bad++;
            $display("FAIL midreset_next_count: got %0d events expected 1", ev_q.size());
        end else begin
            got = ev_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL midreset_next_event: got %h expected %h", got, exp_v);
            end
        end
        held = 8'h53;
        ev_q.delete();
        evc_q.delete();
    endtask

    task automatic test_break();
        logic timed_out;
        logic [12:0] exp_v;
        logic [12:0] got;
        int prev;
        int gc;
        int n;
        exp_v = model_frame(8'h00, 1'b0, 1'b1, held);
        ifc.i_Rx_Serial = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 6 * NBITS * CPB; k++) begin
            wait_cycles(1);
            if (ev_q.size() >= 4) begin
                timed_out = 1'b0;
                break;
            end
        end
        ifc.i_Rx_Serial = 1'b1;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL break_timeout: got %0d frame errors expected 4 within bound", ev_q.size());
        end
        wait_cycles(100);
        total++;
        if (ev_q.size() != 4) begin
            bad++;
            $display("FAIL break_count: got %0d events expected 4", ev_q.size());
        end
        n = ev_q.size();
        prev = 0;
        for (int i = 0; i < n; i++) begin
            got = ev_q.pop_front();
            gc = evc_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL break_event%0d: got %h expected %h", i, got, exp_v);
            end
            if (i > 0) begin
                total++;
                if ((gc - prev) < (NBITS - 1) * CPB || (gc - prev) > (NBITS + 1) * CPB) begin
                    bad++;
                    $display("FAIL break_period: got %0d cycles expected about %0d", gc - prev, NBITS * CPB);
                end
            end
            prev = gc;
        end
        ev_q.delete();
        evc_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int st;
        logic [12:0] exp_v;
        logic [12:0] got;
        for (int f = 0; f < 2; f++) begin
            exp_v = model_frame(8'h53, 1'b1, (f == 0), held);
            send_frame(8'h53, 1'b1, (f != 0), st);
            wait_cycles(4);
            total++;
            if (ev_q.size() != 1) begin
                bad++;
                $display("FAIL parity%0d_count: got %0d events expected 1", f, ev_q.size());
            end else begin
                got = ev_q.pop_front();
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL parity%0d_event: got %h expected %h", f, got, exp_v);
                end
            end
            if (exp_v[12]) held = exp_v[7:0];
            ev_q.delete();
            evc_q.delete();
        end
    endtask
`endif

    task automatic test_random();
        int st;
        int gc;
        int sel;
        int gap;
        logic [7:0] b;
        logic stop_b;
        logic flip;
        logic [12:0] exp_v;
        logic [12:0] got;
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 8'h53;
                1: b = 8'h73;
                2: b = 8'h43;
                3: b = 8'h63;
                default: b = 8'($urandom);
            endcase
            stop_b = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            exp_v = model_frame(b, stop_b, !flip, held);
            send_frame(b, stop_b, flip, st);
            total++;
            if (ev_q.size() != 1) begin
                bad++;
                $display("FAIL rand%0d_count: byte %h got %0d events expected 1", f, b, ev_q.size());
            end else begin
                got = ev_q.pop_front();
                gc = evc_q.pop_front();
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL rand%0d_event: got %h expected %h", f, got, exp_v);
                end
                total++;
                if ((gc - st) < LAT - 1 || (gc - st) > LAT + 1) begin
                    bad++;
                    $display("FAIL rand%0d_latency: got %0d expected %0d+-1", f, gc - st, LAT);
                end
            end
            if (exp_v[12]) held = b;
            ev_q.delete();
            evc_q.delete();
            gap = $urandom_range(stop_b ? 0 : 1, 12);
            wait_cycles(gap);
        end
        total++;
        if (ifc.o_Rx_Byte !== held) begin
            bad++;
            $display("FAIL rand_hold: got %h expected %h", ifc.o_Rx_Byte, held);
        end
    endtask

    initial begin
        ifc.i_Rx_Serial = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_report();
        test_back_to_back();
        test_frame_err();
        test_glitch_and_reset();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
